// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI master slice:
//               FSM state encoding, data word width and SCL edges per word.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_DATA_W = 8;
    localparam int SPI_EDGES  = 2 * SPI_DATA_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_master_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_clk_gen
// Description : SCL half-period timer. Counts 0..CLK_DIV-1 and flags the
//               final count as a one-cycle tick. clr restarts the count so
//               that every FSM state begins a fresh half-period.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'((CLK_DIV > 0) ? CLK_DIV - 1 : 0);

    generate
        if (CLK_DIV < 1) begin : g_bad_clk_div
            $error("spi_clk_gen: CLK_DIV must be at least 1");
        end
    endgenerate

    logic [CW-1:0] cnt;

    // Free-running half-period counter, restarted on clear or at wrap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : Single-clock SPI master. Takes bytes on a valid/ready port,
//               shifts them MSB-first on MOSI while capturing MISO, frames
//               each transfer with CS_n and returns the received byte with a
//               one-cycle rx_valid pulse. CPOL/CPHA select the SPI mode.
//               Optional build macro: SPI_MASTER_BURST_EN - accepts the next
//               byte in the last HOLD cycle and continues under the same
//               CS_n assertion without SETUP/GAP.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master
    import spi_pkg::*;
#(
    parameter int CPOL    = 0,
    parameter int CPHA    = 0,
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SPI_DATA_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [SPI_DATA_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  SCL,
    output logic                  CS_n,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam logic SCL_IDLE    = (CPOL != 0);
    // Sampling happens on the leading SCL edge in mode CPHA=0.
    localparam logic LEAD_SAMPLE = (CPHA == 0);
    localparam int   EW          = $clog2(SPI_EDGES);
    localparam logic [EW-1:0] LAST_EDGE = EW'(SPI_EDGES - 1);

    generate
        if (CLK_DIV < 1) begin : g_bad_clk_div
            $error("spi_master: CLK_DIV must be at least 1");
        end
    endgenerate

    spi_master_state_t     state;
    spi_master_state_t     state_nxt;
    logic                  tick;
    logic                  clr;
    logic [EW-1:0]         edge_cnt;
    logic [EW-1:0]         edge_nxt;
    logic [SPI_DATA_W-1:0] tx_sr;
    logic [SPI_DATA_W-1:0] tx_sr_nxt;
    logic [SPI_DATA_W-1:0] rx_sr;
    logic [SPI_DATA_W-1:0] rx_sr_nxt;
    logic [SPI_DATA_W-1:0] rx_data_nxt;
    logic                  scl_nxt;
    logic                  cs_n_nxt;
    logic                  mosi_nxt;
    logic                  rx_valid_nxt;
    logic                  tx_ready_nxt;
    logic                  busy_nxt;
    logic                  load;
    logic                  leading;
    logic                  hold_ready;

    // Every state change restarts the half-period timer.
    assign clr = (state_nxt != state);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

`ifdef SPI_MASTER_BURST_EN
    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HW-1:0] HOLD_PRE = HW'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);

    logic [HW-1:0] hold_cnt;

    // Cycles spent in HOLD, used to raise tx_ready for its final cycle.
    always_ff @(posedge clk) begin
        if (rst || (state != HOLD)) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

    // The upcoming cycle is the last of HOLD: either HOLD is one cycle long
    // and is being entered now, or the count is one short of the tick.
    assign hold_ready = (state_nxt == HOLD) &&
                        ((state != HOLD) ? (CLK_DIV == 1) : (hold_cnt == HOLD_PRE));
`else
    assign hold_ready = 1'b0;
`endif

    // Next-state and next-output decode; every register is fed from here.
    always_comb begin
        state_nxt    = state;
        scl_nxt      = SCL;
        cs_n_nxt     = CS_n;
        mosi_nxt     = MOSI;
        tx_sr_nxt    = tx_sr;
        rx_sr_nxt    = rx_sr;
        rx_data_nxt  = rx_data;
        rx_valid_nxt = 1'b0;
        edge_nxt     = edge_cnt;
        load         = 1'b0;
        leading      = 1'b0;

        case (state)
            IDLE: begin
                scl_nxt  = SCL_IDLE;
                cs_n_nxt = 1'b1;
                if (tx_valid && tx_ready) begin
                    load      = 1'b1;
                    state_nxt = SETUP;
                end
            end

            SETUP: begin
                if (tick) begin
                    edge_nxt  = '0;
                    state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                if (tick) begin
                    scl_nxt  = ~SCL;
                    edge_nxt = edge_cnt + EW'(1);
                    // Toggles 1,3,..,15 are leading; edge_cnt counts toggles done.
                    leading  = ~edge_cnt[0];
                    if (leading == LEAD_SAMPLE) begin
                        rx_sr_nxt = {rx_sr[SPI_DATA_W-2:0], MISO};
                    end else if (!(LEAD_SAMPLE && (edge_cnt == LAST_EDGE))) begin
                        // In CPHA=0 the final trailing edge has no bit left to present.
                        mosi_nxt  = tx_sr[SPI_DATA_W-1];
                        tx_sr_nxt = {tx_sr[SPI_DATA_W-2:0], 1'b0};
                    end
                    if (edge_cnt == LAST_EDGE) begin
                        state_nxt = HOLD;
                    end
                end
            end

            HOLD: begin
                if (tick) begin
                    rx_data_nxt  = rx_sr;
                    rx_valid_nxt = 1'b1;
`ifdef SPI_MASTER_BURST_EN
                    if (tx_valid && tx_ready) begin
                        load      = 1'b1;
                        state_nxt = SHIFT;
                    end else begin
                        cs_n_nxt  = 1'b1;
                        state_nxt = GAP;
                    end
`else
                    cs_n_nxt  = 1'b1;
                    state_nxt = GAP;
`endif
                end
            end

            GAP: begin
                if (tick) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Accepting a byte: capture it whole so later tx_data changes are inert.
        if (load) begin
            cs_n_nxt = 1'b0;
            edge_nxt = '0;
            if (LEAD_SAMPLE) begin
                mosi_nxt  = tx_data[SPI_DATA_W-1];
                tx_sr_nxt = {tx_data[SPI_DATA_W-2:0], 1'b0};
            end else begin
                tx_sr_nxt = tx_data;
            end
        end

        busy_nxt     = (state_nxt != IDLE);
        tx_ready_nxt = (state_nxt == IDLE) || hold_ready;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered outputs and shift datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            SCL      <= SCL_IDLE;
            CS_n     <= 1'b1;
            MOSI     <= 1'b0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            busy     <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            edge_cnt <= '0;
        end else begin
            SCL      <= scl_nxt;
            CS_n     <= cs_n_nxt;
            MOSI     <= mosi_nxt;
            tx_ready <= tx_ready_nxt;
            rx_valid <= rx_valid_nxt;
            rx_data  <= rx_data_nxt;
            busy     <= busy_nxt;
            tx_sr    <= tx_sr_nxt;
            rx_sr    <= rx_sr_nxt;
            edge_cnt <= edge_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master
// Description : Self-checking bench for spi_master. Five instances cover the
//               four CPOL/CPHA modes and CLK_DIV of 4, 2 and 1. Expected
//               received bytes are queued at stimulus time and popped when
//               rx_valid pulses. Build macro SPI_MASTER_BURST_EN switches the
//               streaming expectations to one CS_n frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0][7:0]  tx_d;
    logic [4:0]       tx_valid;
    logic [4:0]       tx_ready;
    logic [4:0][7:0]  rx_d;
    logic [4:0]       rx_valid;
    logic [4:0]       busy;
    logic [4:0]       scl;
    logic [4:0]       cs_n;
    logic [4:0]       mosi;
    logic [4:0]       miso;

    logic [4:0]       cpol_v = 5'b01100;
    logic [4:0]       cpha_v = 5'b01010;
    int               div_v [5] = '{4, 4, 2, 2, 1};

    logic [7:0]       slv_sr;
    logic             use_slave = 1'b0;
    exp_t             exp_q [$];
    exp_t             mon_e;
    int               errors = 0;
    int               checks = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 5; g++) begin : g_dut
            spi_master #(
                .CPOL    ((g == 2 || g == 3) ? 1 : 0),
                .CPHA    ((g == 1 || g == 3) ? 1 : 0),
                .CLK_DIV ((g <= 1) ? 4 : ((g == 4) ? 1 : 2))
            ) u_dut (
                .clk      (clk),
                .rst      (rst),
                .tx_data  (tx_d[g]),
                .tx_valid (tx_valid[g]),
                .tx_ready (tx_ready[g]),
                .rx_data  (rx_d[g]),
                .rx_valid (rx_valid[g]),
                .busy     (busy[g]),
                .SCL      (scl[g]),
                .CS_n     (cs_n[g]),
                .MOSI     (mosi[g]),
                .MISO     (miso[g])
            );
        end
    endgenerate

    // Instance 0 talks to a mode-0 slave or loops back; the rest loop back.
    assign miso = {mosi[4:1], use_slave ? slv_sr[7] : mosi[0]};

    // Mode-0 slave: load reply on CS_n fall, shift on each SCL fall.
    always @(negedge cs_n[0]) slv_sr = 8'h3C;
    always @(negedge scl[0]) if (cs_n[0] === 1'b0) slv_sr = {slv_sr[6:0], 1'b0};

    // Scoreboard: every rx_valid pops the oldest expected byte.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 5; i++) begin
                if (rx_valid[i] === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rx_unexpected inst=%0d got=%02h expected no pulse", i, rx_d[i]);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.idx != 3'(i) || rx_d[i] !== mon_e.data) begin
                            errors++;
                            $display("FAIL rx_data inst=%0d got=%02h expected inst=%0d data=%02h",
                                     i, rx_d[i], mon_e.idx, mon_e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_ready(input int idx);
        int n = 0;
        while (tx_ready[idx] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (tx_ready[idx] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout inst=%0d got tx_ready=%b expected 1", idx, tx_ready[idx]);
        end
    endtask

    // One framed byte; reports what was seen on the SPI pins and when.
    task automatic run_frame(input int idx, input logic [7:0] b, input logic [7:0] exp_rx,
                             input bit zap, output int toggles, output int samples,
                             output logic [7:0] cap, output int rxv_cyc, output int rdy_cyc,
                             output logic busy1, output bit stable);
        logic pscl, pmosi, lead;
        toggles = 0; samples = 0; cap = '0; rxv_cyc = -1; rdy_cyc = -1; busy1 = 1'b0; stable = 1'b1;
        wait_ready(idx);
        tx_d[idx]     = b;
        tx_valid[idx] = 1'b1;
        exp_q.push_back('{idx: 3'(idx), data: exp_rx});
        pscl  = scl[idx];
        pmosi = mosi[idx];
        @(negedge clk);
        tx_valid[idx] = 1'b0;
        if (zap) tx_d[idx] = 8'h00;
        for (int c = 1; c <= 2000; c++) begin
            if (c == 1) busy1 = busy[idx];
            if (scl[idx] !== pscl) begin
                toggles++;
                lead = (pscl === cpol_v[idx]);
                if (lead != cpha_v[idx]) begin
                    samples++;
                    cap = {cap[6:0], mosi[idx]};
                    if (mosi[idx] !== pmosi) stable = 1'b0;
                end
            end
            if (rx_valid[idx] === 1'b1 && rxv_cyc < 0) rxv_cyc = c;
            if (tx_ready[idx] === 1'b1) begin
                rdy_cyc = c;
                break;
            end
            pscl  = scl[idx];
            pmosi = mosi[idx];
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int rxp = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({scl, cs_n, mosi, tx_ready, rx_valid, busy} !== {cpol_v, 5'h1f, 5'h00, 5'h00, 5'h00, 5'h00}) begin
            errors++;
            $display("FAIL reset_pins got scl=%b cs_n=%b mosi=%b rdy=%b rxv=%b busy=%b expected scl=%b cs_n=11111 others 0",
                     scl, cs_n, mosi, tx_ready, rx_valid, busy, cpol_v);
        end
        checks++;
        if (rx_d !== '0) begin
            errors++;
            $display("FAIL reset_rx_data got=%h expected 0", rx_d);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_ready !== 5'h1f) begin
            errors++;
            $display("FAIL ready_after_reset got=%b expected 11111", tx_ready);
        end
        // Start a byte on instance 0 and reset it half way through.
        tx_d[0] = 8'h5A;
        tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if ({busy[0], cs_n[0]} !== 2'b10) begin
            errors++;
            $display("FAIL midxfer_active got busy=%b cs_n=%b expected busy=1 cs_n=0", busy[0], cs_n[0]);
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({scl[0], cs_n[0], tx_ready[0], rx_valid[0], busy[0], mosi[0]} !== {cpol_v[0], 5'b10000}) begin
                errors++;
                $display("FAIL midxfer_reset cyc=%0d got scl=%b cs_n=%b rdy=%b rxv=%b busy=%b mosi=%b expected %b,1,0,0,0,0",
                         k, scl[0], cs_n[0], tx_ready[0], rx_valid[0], busy[0], mosi[0], cpol_v[0]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL midxfer_ready got=%b expected 1", tx_ready[0]);
        end
        for (int k = 0; k < 100; k++) begin
            if (rx_valid[0] === 1'b1) rxp++;
            @(negedge clk);
        end
        checks++;
        if (rxp != 0 || cs_n[0] !== 1'b1) begin
            errors++;
            $display("FAIL midxfer_abandon got rx_pulses=%0d cs_n=%b expected 0 and 1", rxp, cs_n[0]);
        end
    endtask

    task automatic test_basic();
        int tog, smp, rxc, rdc;
        logic [7:0] cap;
        logic b1;
        bit st;
        use_slave = 1'b1;
        run_frame(0, 8'hA5, 8'h3C, 1'b0, tog, smp, cap, rxc, rdc, b1, st);
        use_slave = 1'b0;
        checks++;
        if (smp != 8 || tog != 16) begin
            errors++;
            $display("FAIL basic_edges got rises=%0d toggles=%0d expected 8 and 16", smp, tog);
        end
        checks++;
        if (cap !== 8'hA5 || !st) begin
            errors++;
            $display("FAIL basic_mosi got=%02h stable=%0d expected a5 stable=1", cap, st);
        end
        checks++;
        if (rxc != 73) begin
            errors++;
            $display("FAIL basic_rx_latency got=%0d expected 73", rxc);
        end
        checks++;
        if (rdc != 77) begin
            errors++;
            $display("FAIL basic_ready_latency got=%0d expected 77", rdc);
        end
        checks++;
        if (b1 !== 1'b1 || busy[0] !== 1'b0 || cs_n[0] !== 1'b1 || rx_d[0] !== 8'h3C) begin
            errors++;
            $display("FAIL basic_final got busy1=%b busy=%b cs_n=%b rx=%02h expected 1,0,1,3c",
                     b1, busy[0], cs_n[0], rx_d[0]);
        end
    endtask

    task automatic test_modes();
        int tog, smp, rxc, rdc;
        logic [7:0] cap;
        logic b1, idle0;
        bit st;
        for (int i = 0; i < 4; i++) begin
            idle0 = scl[i];
            run_frame(i, 8'h81, 8'h81, 1'b0, tog, smp, cap, rxc, rdc, b1, st);
            checks++;
            if (idle0 !== cpol_v[i] || scl[i] !== cpol_v[i]) begin
                errors++;
                $display("FAIL mode%0d_idle got before=%b after=%b expected %b", i, idle0, scl[i], cpol_v[i]);
            end
            checks++;
            if (cap !== 8'h81 || rx_d[i] !== 8'h81 || tog != 16 || !st) begin
                errors++;
                $display("FAIL mode%0d_data got mosi=%02h rx=%02h toggles=%0d stable=%0d expected 81,81,16,1",
                         i, cap, rx_d[i], tog, st);
            end
            checks++;
            if (rxc != 18 * div_v[i] + 1 || rdc != 19 * div_v[i] + 1) begin
                errors++;
                $display("FAIL mode%0d_latency got rx=%0d rdy=%0d expected %0d and %0d",
                         i, rxc, rdc, 18 * div_v[i] + 1, 19 * div_v[i] + 1);
            end
        end
    endtask

    task automatic test_data_change();
        int tog, smp, rxc, rdc;
        logic [7:0] cap;
        logic b1;
        bit st;
        run_frame(0, 8'hC3, 8'hC3, 1'b1, tog, smp, cap, rxc, rdc, b1, st);
        checks++;
        if (cap !== 8'hC3 || rx_d[0] !== 8'hC3) begin
            errors++;
            $display("FAIL data_change got mosi=%02h rx=%02h expected c3", cap, rx_d[0]);
        end
    endtask

    // Bytes streamed with tx_valid held; framing depends on the burst build.
    task automatic test_back_to_back(input int idx, input int n, input logic [2:0][7:0] bytes);
        int acc, frames, rxp, gap, stray, exp_frames, per_frame;
        int tog [3];
        bit hs, done;
        logic pscl, pcs;
`ifdef SPI_MASTER_BURST_EN
        exp_frames = 1;
`else
        exp_frames = n;
`endif
        per_frame = 16 * n / exp_frames;
        acc = 0; frames = 0; rxp = 0; gap = 0; stray = 0; done = 1'b0;
        tog = '{0, 0, 0};
        wait_ready(idx);
        tx_d[idx]     = bytes[0];
        tx_valid[idx] = 1'b1;
        exp_q.push_back('{idx: 3'(idx), data: bytes[0]});
        hs   = tx_ready[idx];
        pscl = scl[idx];
        pcs  = cs_n[idx];
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (hs) begin
                acc++;
                if (acc < n) begin
                    tx_d[idx] = bytes[acc];
                    exp_q.push_back('{idx: 3'(idx), data: bytes[acc]});
                end else begin
                    tx_valid[idx] = 1'b0;
                end
            end
            if (pcs === 1'b1 && cs_n[idx] === 1'b0) frames++;
            if (scl[idx] !== pscl) begin
                if (cs_n[idx] === 1'b0 && frames >= 1 && frames <= 3) tog[frames-1]++;
                else stray++;
            end
            if (cs_n[idx] === 1'b1 && frames >= 1 && frames < n) gap++;
            if (rx_valid[idx] === 1'b1) rxp++;
            hs   = tx_valid[idx] && tx_ready[idx];
            pscl = scl[idx];
            pcs  = cs_n[idx];
            if (acc == n && rxp == n && tx_ready[idx] === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done || frames != exp_frames || rxp != n) begin
            errors++;
            $display("FAIL stream%0d_frames got done=%0d frames=%0d rx_pulses=%0d expected 1,%0d,%0d",
                     idx, done, frames, rxp, exp_frames, n);
        end
        checks++;
        if (tog[0] != per_frame || (exp_frames > 1 && tog[1] != per_frame) || stray != 0) begin
            errors++;
            $display("FAIL stream%0d_toggles got %0d,%0d stray=%0d expected %0d each stray=0",
                     idx, tog[0], tog[1], stray, per_frame);
        end
        if (exp_frames > 1) begin
            checks++;
            if (gap < 1) begin
                errors++;
                $display("FAIL stream%0d_gap got=%0d expected >=1", idx, gap);
            end
        end
    endtask

    initial begin
        tx_d     = '0;
        tx_valid = '0;
        test_reset();
        test_basic();
        test_modes();
        test_data_change();
        test_back_to_back(4, 2, {8'h00, 8'h00, 8'hFF});
        test_back_to_back(0, 3, {8'h56, 8'h34, 8'h12});
        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
